// File: rtl/ofm_writeback.sv
// OFM writeback: aligns adder-tree sums with their issue strobe, accumulates channel passes,
// quantizes (round, shift, ReLU, saturate) and streams pixels to the OFM buffer through a small FIFO.
module ofm_writeback #(
    parameter int unsigned IN_WIDTH     = 20,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned TREE_LATENCY = 4,
    parameter int unsigned CH_WIDTH     = 5,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CH_WIDTH-1:0]         cfg_num_ch,
    input  logic [ADDR_WIDTH-1:0]       cfg_num_pix,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_relu_en,
    input  logic                        issue_valid,
    input  logic signed [IN_WIDTH-1:0]  tree_sum,
    output logic                        in_ready,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic signed [OUT_WIDTH-1:0] wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = $clog2(TREE_LATENCY + 1);
    localparam int unsigned OCC_W = CNT_W + INF_W;
    localparam int unsigned RW    = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] Q_MAX = RW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] Q_MIN = ~Q_MAX;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic signed [OUT_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                       state;
    logic [CH_WIDTH-1:0]          num_ch_q;
    logic [ADDR_WIDTH-1:0]        num_pix_q;
    logic [4:0]                   shift_q;
    logic                         relu_q;
    logic [TREE_LATENCY-1:0]      vld_sr;
    logic [CH_WIDTH-1:0]          ch_cnt;
    logic [ADDR_WIDTH-1:0]        pix_cnt;
    logic signed [ACC_WIDTH-1:0]  acc;

    wb_entry_t                    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             fifo_cnt;

    logic [CH_WIDTH-1:0]          num_ch_eff;
    logic                         sample;
    logic                         complete;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [RW-1:0]         rnd;
    logic signed [RW-1:0]         rounded;
    logic signed [RW-1:0]         q;
    logic signed [RW-1:0]         q_sat;
    logic signed [OUT_WIDTH-1:0]  pix_data;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         drop;
    logic                         wr_en;
    logic [INF_W-1:0]             inflight;

    // Datapath: accumulate, then round/shift/ReLU/saturate the completed pixel
    always_comb begin
        num_ch_eff = (num_ch_q == '0) ? CH_WIDTH'(1) : num_ch_q;
        sample     = vld_sr[TREE_LATENCY-1] && (state == S_RUN);
        sum        = acc + ACC_WIDTH'(tree_sum);
        complete   = !(ch_cnt < (num_ch_eff - CH_WIDTH'(1)));
        rnd        = '0;
        if (shift_q != 5'd0) begin
            rnd = RW'(1) << (shift_q - 5'd1);
        end
        rounded = RW'(sum) + rnd;
        q       = rounded >>> shift_q;
        if (relu_q && (q < 0)) begin
            q = '0;
        end
        q_sat = q;
        if (q > Q_MAX) begin
            q_sat = Q_MAX;
        end else if (q < Q_MIN) begin
            q_sat = Q_MIN;
        end
        pix_data = OUT_WIDTH'(q_sat);

        push     = sample && complete;
        pop      = (fifo_cnt != '0) && wr_ready;
        full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        drop     = push && full && !pop;
        wr_en    = push && !drop;
        inflight = INF_W'($countones(vld_sr));
    end

    // Every set tap may still turn into a push, so upstream is throttled against all of them
    assign in_ready = (state == S_RUN) &&
                      ((OCC_W'(fifo_cnt) + OCC_W'(inflight)) < OCC_W'(FIFO_DEPTH));
    assign wr_valid = (fifo_cnt != '0);
    assign wr_addr  = mem[rd_ptr].addr;
    assign wr_data  = mem[rd_ptr].data;

    // Frame control, alignment delay line and channel accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            num_ch_q  <= '0;
            num_pix_q <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            vld_sr    <= '0;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[TREE_LATENCY-2:0], issue_valid};
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        num_ch_q  <= cfg_num_ch;
                        num_pix_q <= cfg_num_pix;
                        shift_q   <= cfg_shift;
                        relu_q    <= cfg_relu_en;
                        vld_sr    <= '0;
                        ch_cnt    <= '0;
                        pix_cnt   <= '0;
                        acc       <= '0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pix_cnt == num_pix_q) begin
                        state <= S_DRAIN;
                    end
                    if (sample) begin
                        if (complete) begin
                            acc     <= '0;
                            ch_cnt  <= '0;
                            pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
                        end else begin
                            acc    <= sum;
                            ch_cnt <= ch_cnt + CH_WIDTH'(1);
                        end
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO; a push into a full FIFO is kept when the head pops in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{addr: pix_cnt, data: pix_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: adder-tree stand-in, write monitor and a pixel-level reference model.
module tb_ofm_writeback;

    localparam int IW = 20;
    localparam int OW = 8;
    localparam int TL = 4;
    localparam int CW = 5;
    localparam int ADW = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [CW-1:0] cfg_num_ch;
    logic [ADW-1:0] cfg_num_pix;
    logic [4:0] cfg_shift;
    logic cfg_relu_en;
    logic issue_valid;
    logic signed [IW-1:0] tree_sum;
    logic in_ready;
    logic wr_valid;
    logic wr_ready;
    logic [ADW-1:0] wr_addr;
    logic signed [OW-1:0] wr_data;
    logic busy;
    logic done;
    logic overflow;

    int errors = 0;
    int checks = 0;
    int issue_to = 0;
    int issued = 0;
    int done_cnt = 0;
    int got_addr[$];
    int got_data[$];
    int exp_addr[$];
    int exp_data[$];
    logic signed [IW-1:0] cur_v;
    logic signed [IW-1:0] pipe [TL];

    ofm_writeback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_ch(cfg_num_ch),
        .cfg_num_pix(cfg_num_pix), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .issue_valid(issue_valid), .tree_sum(tree_sum), .in_ready(in_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Adder-tree stand-in: the issued value emerges TL cycles later, junk otherwise
    always @(posedge clk) begin
        for (int i = TL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= issue_valid ? cur_v : IW'($urandom);
    end
    assign tree_sum = pipe[TL-1];

    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
        end
        if (rst_n && done) done_cnt++;
    end

    // Pixel value from its channel sums: 24-bit wrap, round-half-up shift, ReLU, 8-bit saturation
    function automatic int model_pix(input int sums[$], input int sh, input bit relu);
        longint t = 0;
        longint r;
        longint q;
        foreach (sums[i]) begin
            t = t + longint'(sums[i]);
            t = t & longint'(32'h00FF_FFFF);
            if (t >= longint'(32'h0080_0000)) t = t - longint'(32'h0100_0000);
        end
        r = t + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
        q = r >>> sh;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic issue(input int v, input bit force_it);
        int n;
        n = 0;
        if (!force_it) begin
            while (!in_ready && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) issue_to++;
        end
        issue_valid = 1'b1;
        cur_v = IW'(v);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        issued++;
    endtask

    task automatic send_pixel(input int sums[$], input int sh, input bit relu, input int addr,
                              input bit force_it, input bit expect_it);
        if (expect_it) begin
            exp_addr.push_back(addr);
            exp_data.push_back(model_pix(sums, sh, relu));
        end
        foreach (sums[i]) issue(sums[i], force_it);
    endtask

    task automatic start_frame(input int nch, input int npix, input int sh, input bit relu);
        @(posedge clk); #1;
        cfg_num_ch = CW'(nch);
        cfg_num_pix = ADW'(npix);
        cfg_shift = 5'(sh);
        cfg_relu_en = relu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
        issued = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; issue_valid = 0; wr_ready = 0; cur_v = '0;
        cfg_num_ch = '0; cfg_num_pix = '0; cfg_shift = '0; cfg_relu_en = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, wr_valid, busy, done, overflow} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, wr_valid, busy, done, overflow});
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL reset_head: got addr=%0d data=%0d want 0/0", wr_addr, wr_data);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        // issues while idle must not produce writes
        repeat (3) begin
            cur_v = IW'(9); issue_valid = 1'b1; @(posedge clk); #1;
        end
        issue_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_issue: got wr_valid=%b busy=%b want 0/0", wr_valid, busy);
        end
    endtask

    task automatic test_basic();
        int d0, lat;
        bit seen;
        wr_ready = 1'b1;
        start_frame(1, 3, 0, 0);
        d0 = done_cnt;
        lat = -1;
        send_pixel('{5}, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wr_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk);
        end
        // k counts from the cycle after the issue, so the issue-to-valid distance is k+... see below
        lat = lat - 1;
        @(posedge clk); #1;
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL basic_latency: got %0d want 5", lat);
        end
        send_pixel('{-3}, 0, 0, 1, 0, 1);
        send_pixel('{200}, 0, 0, 2, 0, 1);
        wait_done(200, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL basic_done: got no done want done");
        end
        checks++;
        if (got_addr.size() !== 3) begin
            errors++; $display("FAIL basic_count: got %0d want 3", got_addr.size());
        end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL basic_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy: got %b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL basic_pulse: got done=%b pulses=%0d want 0/1", done, done_cnt - d0);
        end
    endtask

    task automatic test_accum();
        bit seen;
        wr_ready = 1'b1;
        start_frame(3, 2, 2, 0);
        send_pixel('{10, 7, -4}, 2, 0, 0, 0, 1);
        send_pixel('{1, 1, 1}, 2, 0, 1, 0, 1);
        wait_done(200, seen);
        checks++;
        if (!seen || got_addr.size() !== 2) begin
            errors++; $display("FAIL accum_count: got done=%b n=%0d want 1/2", seen, got_addr.size());
        end
        for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL accum_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_relu_sat();
        bit seen;
        wr_ready = 1'b1;
        start_frame(1, 3, 0, 1);
        send_pixel('{-50}, 0, 1, 0, 0, 1);
        send_pixel('{-300}, 0, 1, 1, 0, 1);
        send_pixel('{40}, 0, 1, 2, 0, 1);
        wait_done(200, seen);
        checks++;
        if (!seen || got_addr.size() !== 3) begin
            errors++; $display("FAIL relu_count: got done=%b n=%0d want 1/3", seen, got_addr.size());
        end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL relu_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        start_frame(1, 1, 0, 0);
        send_pixel('{-300}, 0, 0, 0, 0, 1);
        wait_done(200, seen);
        checks++;
        if (!seen || got_data.size() !== 1 || got_data[0] !== exp_data[0]) begin
            errors++; $display("FAIL sat_neg: got n=%0d data=%0d want 1/%0d", got_data.size(),
                               (got_data.size() > 0) ? got_data[0] : 0, exp_data[0]);
        end
    endtask

    task automatic test_stall();
        bit seen;
        int max_issued, unstable;
        logic [ADW-1:0] h_addr;
        logic signed [OW-1:0] h_data;
        bit have_head;
        max_issued = 0; unstable = 0; have_head = 0; h_addr = '0; h_data = '0;
        wr_ready = 1'b0;
        start_frame(1, 6, 0, 0);
        fork
            begin
                for (int i = 0; i < 6; i++) send_pixel('{i * 17 - 30}, 0, 0, i, 0, 1);
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (issued > max_issued) max_issued = issued;
                    if (wr_valid) begin
                        if (have_head && (wr_addr !== h_addr || wr_data !== h_data)) unstable++;
                        h_addr = wr_addr; h_data = wr_data; have_head = 1;
                    end
                end
                @(posedge clk); #1;
                wr_ready = 1'b1;
            end
        join
        wait_done(300, seen);
        checks++;
        if (max_issued > 4 || max_issued < 1) begin
            errors++; $display("FAIL stall_buffered: got %0d want 1..4", max_issued);
        end
        checks++;
        if (unstable !== 0 || !have_head) begin
            errors++; $display("FAIL stall_head: got unstable=%0d seen=%b want 0/1", unstable, have_head);
        end
        checks++;
        if (overflow !== 1'b0 || !seen || got_addr.size() !== 6) begin
            errors++; $display("FAIL stall_end: got ovf=%b done=%b n=%0d want 0/1/6", overflow, seen, got_addr.size());
        end
        for (int i = 0; i < 6 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL stall_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit seen;
        wr_ready = 1'b0;
        start_frame(1, 5, 0, 0);
        for (int i = 0; i < 5; i++) send_pixel('{i + 1}, 0, 0, i, 1, i < 4);
        repeat (10) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_flag: got ovf=%b busy=%b in_ready=%b want 1/1/0", overflow, busy, in_ready);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_done(200, seen);
        checks++;
        if (!seen || got_addr.size() !== 4 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_done: got done=%b n=%0d ovf=%b want 1/4/1", seen, got_addr.size(), overflow);
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL ovf_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        start_frame(1, 1, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        send_pixel('{3}, 0, 0, 0, 0, 1);
        wait_done(200, seen);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int d0;
        wr_ready = 1'b0;
        start_frame(1, 4, 0, 0);
        send_pixel('{11}, 0, 0, 0, 0, 0);
        send_pixel('{12}, 0, 0, 1, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (wr_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got wr_valid=%b busy=%b want 1/1", wr_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_valid, busy, done, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL rstmid_out: got ctl=%b addr=%0d data=%0d want 0", {in_ready, wr_valid, busy, done, overflow}, wr_addr, wr_data);
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || wr_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort: got pulses=%0d wr_valid=%b want 0/0", done_cnt - d0, wr_valid);
        end
        wr_ready = 1'b1;
        start_frame(1, 1, 0, 0);
        send_pixel('{77}, 0, 0, 0, 0, 1);
        wait_done(200, seen);
        checks++;
        if (!seen || got_addr.size() !== 1 || got_addr[0] !== 0 || got_data[0] !== exp_data[0]) begin
            errors++; $display("FAIL rstmid_after: got done=%b n=%0d want 1/1 at addr 0 data %0d", seen, got_addr.size(), exp_data[0]);
        end
    endtask

    task automatic test_random();
        bit seen, fin, relu;
        int nch, eff, sh;
        int s[$];
        for (int f = 0; f < 3; f++) begin
            nch = $urandom_range(0, 4);
            eff = (nch == 0) ? 1 : nch;
            sh = $urandom_range(0, 10);
            relu = 1'($urandom_range(0, 1));
            fin = 0;
            seen = 0;
            wr_ready = 1'b1;
            start_frame(nch, 6, sh, relu);
            fork
                begin
                    for (int p = 0; p < 6; p++) begin
                        s.delete();
                        for (int c = 0; c < eff; c++) begin
                            if ($urandom_range(0, 1) == 1) s.push_back($urandom_range(0, 1200) - 600);
                            else s.push_back(int'($urandom_range(0, 1048575)) - 524288);
                        end
                        send_pixel(s, sh, relu, p, 0, 1);
                    end
                    wait_done(500, seen);
                    fin = 1;
                end
                begin
                    for (int n = 0; n < 2000 && !fin; n++) begin
                        @(posedge clk); #1;
                        wr_ready = 1'($urandom_range(0, 1));
                    end
                    wr_ready = 1'b1;
                end
            join
            checks++;
            if (!seen || got_addr.size() !== 6) begin
                errors++; $display("FAIL rand%0d_count: got done=%b n=%0d want 1/6", f, seen, got_addr.size());
            end
            for (int i = 0; i < 6 && i < got_addr.size(); i++) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    errors++; $display("FAIL rand%0d_pix%0d: got (%0d,%0d) want (%0d,%0d) ch=%0d sh=%0d relu=%0d",
                                       f, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i], nch, sh, relu);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_accum();
        test_relu_sat();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        checks++;
        if (issue_to !== 0) begin
            errors++; $display("FAIL issue_wait: got %0d in_ready timeouts want 0", issue_to);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
